// File: rtl/mc_axi4_mem_responder_pkg.sv
// Shared AXI4 constants and bus-width helpers for the memory responder.
// The mosi/miso bus structs depend on the instance widths, so the
// responder and its users declare them locally from these helpers.
package mc_axi4_mem_responder_pkg;

  // Burst type encodings (AxBURST).
  localparam logic [1:0] axi4_burst_fixed_gc = 2'b00;
  localparam logic [1:0] axi4_burst_incr_gc  = 2'b01;
  localparam logic [1:0] axi4_burst_wrap_gc  = 2'b10;

  // Response encodings (BRESP/RRESP).
  localparam logic [1:0] axi4_resp_okay_gc   = 2'b00;
  localparam logic [1:0] axi4_resp_slverr_gc = 2'b10;

  // User sideband width carried on every channel of this bus.
  localparam int axi_user_width_gp = 1;

  // clog2 that never returns 0, so a depth-1 array still gets a 1-bit index.
  function automatic int safe_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  // Master-to-slave bits: AW and AR (id, addr, len, size, burst, lock,
  // cache, prot, qos, region, user, valid), W (data, strb, last, user,
  // valid), bready and rready.
  function automatic int axi4_mosi_bus_width(input int user_w, input int id_w,
                                             input int addr_w, input int data_w);
    return 2 * (id_w + addr_w + user_w + 30) + data_w + (data_w / 8) + user_w + 4;
  endfunction

  // Slave-to-master bits: awready, wready, B (id, resp, user, valid),
  // arready, R (id, data, resp, last, user, valid).
  function automatic int axi4_miso_bus_width(input int user_w, input int id_w,
                                             input int addr_w, input int data_w);
    return 2 * id_w + data_w + 2 * user_w + 10 + 0 * addr_w;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-ported synchronous RAM with per-byte write enables and a
// registered read port. Each byte lane is its own array so the tools map
// it onto block RAM byte-write enables.
module bsg_mem_1rw_sync_mask_write_byte
  import mc_axi4_mem_responder_pkg::*;
#(
  parameter int els_p        = 256,
  parameter int data_width_p = 32,
  localparam int addr_width_lp = safe_clog2(els_p),
  localparam int bytes_lp      = data_width_p / 8
)(
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [addr_width_lp-1:0] addr,
  input  logic [data_width_p-1:0]  wdata,
  input  logic [bytes_lp-1:0]      wmask,
  output logic [data_width_p-1:0]  rdata
);

  for (genvar gi = 0; gi < bytes_lp; gi++) begin : lane
    logic [7:0] mem_array [els_p];
    logic [7:0] rdata_reg;

    // Byte lane: masked write, or read into the output register. The output
    // holds its value until the next read so a stalled consumer sees it.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (wmask[gi]) begin
            mem_array[addr] <= wdata[8*gi +: 8];
          end
        end else begin
          rdata_reg <= mem_array[addr];
        end
      end
    end

    assign rdata[8*gi +: 8] = rdata_reg;
  end

endmodule

// File: rtl/mc_axi4_mem_responder.sv
// AXI4 slave backed by a byte-masked single-ported RAM. Serves one INCR
// burst at a time; reads and writes share the RAM and alternate when both
// address channels are requesting together.
module mc_axi4_mem_responder
  import mc_axi4_mem_responder_pkg::*;
#(
  parameter int axi_id_width_p   = 4,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32,
  parameter int mem_els_p        = 256,
  localparam int lg_mem_els_lp  = safe_clog2(mem_els_p),
  localparam int byte_offset_lp = safe_clog2(axi_data_width_p >> 3),
  localparam int mosi_width_lp  = axi4_mosi_bus_width(axi_user_width_gp, axi_id_width_p,
                                                      axi_addr_width_p, axi_data_width_p),
  localparam int miso_width_lp  = axi4_miso_bus_width(axi_user_width_gp, axi_id_width_p,
                                                      axi_addr_width_p, axi_data_width_p)
)(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [mosi_width_lp-1:0] s_axi4_bus_i,
  output logic [miso_width_lp-1:0] s_axi4_bus_o
);

  localparam int strb_width_lp = axi_data_width_p / 8;

  typedef struct packed {
    logic [axi_id_width_p-1:0]    awid;
    logic [axi_addr_width_p-1:0]  awaddr;
    logic [7:0]                   awlen;
    logic [2:0]                   awsize;
    logic [1:0]                   awburst;
    logic                         awlock;
    logic [3:0]                   awcache;
    logic [2:0]                   awprot;
    logic [3:0]                   awqos;
    logic [3:0]                   awregion;
    logic [axi_user_width_gp-1:0] awuser;
    logic                         awvalid;
    logic [axi_data_width_p-1:0]  wdata;
    logic [strb_width_lp-1:0]     wstrb;
    logic                         wlast;
    logic [axi_user_width_gp-1:0] wuser;
    logic                         wvalid;
    logic                         bready;
    logic [axi_id_width_p-1:0]    arid;
    logic [axi_addr_width_p-1:0]  araddr;
    logic [7:0]                   arlen;
    logic [2:0]                   arsize;
    logic [1:0]                   arburst;
    logic                         arlock;
    logic [3:0]                   arcache;
    logic [2:0]                   arprot;
    logic [3:0]                   arqos;
    logic [3:0]                   arregion;
    logic [axi_user_width_gp-1:0] aruser;
    logic                         arvalid;
    logic                         rready;
  } mosi_s;

  typedef struct packed {
    logic                         awready;
    logic                         wready;
    logic [axi_id_width_p-1:0]    bid;
    logic [1:0]                   bresp;
    logic [axi_user_width_gp-1:0] buser;
    logic                         bvalid;
    logic                         arready;
    logic [axi_id_width_p-1:0]    rid;
    logic [axi_data_width_p-1:0]  rdata;
    logic [1:0]                   rresp;
    logic                         rlast;
    logic [axi_user_width_gp-1:0] ruser;
    logic                         rvalid;
  } miso_s;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_DATA
  } state_e;

  mosi_s mosi;
  miso_s miso;

  assign mosi         = s_axi4_bus_i;
  assign s_axi4_bus_o = miso;

  state_e                    state_reg, state_next;
  logic [axi_id_width_p-1:0] id_reg, id_next;
  logic [lg_mem_els_lp-1:0]  addr_reg, addr_next;
  logic [7:0]                len_reg, len_next;
  logic [7:0]                beat_cnt_reg, beat_cnt_next;
  // High when the most recent grant went to the read channel.
  logic                      grant_read_reg, grant_read_next;

  logic                        grant_write;
  logic                        grant_read;
  logic                        last_beat;
  logic                        mem_en;
  logic                        mem_we;
  logic [axi_data_width_p-1:0] mem_rdata;

  // Cache, prot, lock, qos, region, user, wlast and the upper address bits
  // carry nothing this responder needs.
  logic unused_bits;
  assign unused_bits = ^mosi;

  // With both channels requesting, the one not served last time wins.
  assign grant_write = mosi.awvalid & (~mosi.arvalid | grant_read_reg);
  assign grant_read  = mosi.arvalid & (~mosi.awvalid | ~grant_read_reg);
  assign last_beat   = (beat_cnt_reg == len_reg);

  // Next-state, datapath updates and all bus outputs.
  always_comb begin
    state_next      = state_reg;
    id_next         = id_reg;
    addr_next       = addr_reg;
    len_next        = len_reg;
    beat_cnt_next   = beat_cnt_reg;
    grant_read_next = grant_read_reg;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    miso            = '0;

    case (state_reg)
      IDLE: begin
        miso.awready = grant_write;
        miso.arready = grant_read;
        if (grant_write) begin
          id_next         = mosi.awid;
          addr_next       = mosi.awaddr[byte_offset_lp +: lg_mem_els_lp];
          len_next        = mosi.awlen;
          beat_cnt_next   = '0;
          grant_read_next = 1'b0;
          state_next      = WR_DATA;
        end else if (grant_read) begin
          id_next         = mosi.arid;
          addr_next       = mosi.araddr[byte_offset_lp +: lg_mem_els_lp];
          len_next        = mosi.arlen;
          beat_cnt_next   = '0;
          grant_read_next = 1'b1;
          state_next      = RD_REQ;
        end
      end

      WR_DATA: begin
        miso.wready = 1'b1;
        if (mosi.wvalid) begin
          mem_en        = 1'b1;
          mem_we        = 1'b1;
          addr_next     = addr_reg + lg_mem_els_lp'(1);
          beat_cnt_next = beat_cnt_reg + 8'd1;
          // Burst length comes from awlen; wlast is not trusted for framing.
          if (last_beat) begin
            state_next = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        miso.bvalid = 1'b1;
        miso.bid    = id_reg;
        miso.bresp  = axi4_resp_okay_gc;
        if (mosi.bready) begin
          state_next = IDLE;
        end
      end

      RD_REQ: begin
        mem_en     = 1'b1;
        state_next = RD_DATA;
      end

      RD_DATA: begin
        // RAM output register is only reloaded in RD_REQ, so rdata holds
        // steady for as long as the master stalls.
        miso.rvalid = 1'b1;
        miso.rid    = id_reg;
        miso.rdata  = mem_rdata;
        miso.rresp  = axi4_resp_okay_gc;
        miso.rlast  = last_beat;
        if (mosi.rready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            addr_next     = addr_reg + lg_mem_els_lp'(1);
            beat_cnt_next = beat_cnt_reg + 8'd1;
            state_next    = RD_REQ;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and transaction context registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      id_reg         <= '0;
      addr_reg       <= '0;
      len_reg        <= '0;
      beat_cnt_reg   <= '0;
      grant_read_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      id_reg         <= id_next;
      addr_reg       <= addr_next;
      len_reg        <= len_next;
      beat_cnt_reg   <= beat_cnt_next;
      grant_read_reg <= grant_read_next;
    end
  end

  // Flag requests for beat sizes or burst types the responder cannot honour.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_reg == IDLE) begin
      if (grant_write) begin
        assert (mosi.awsize == 3'(byte_offset_lp) && mosi.awburst == axi4_burst_incr_gc);
      end
      if (grant_read) begin
        assert (mosi.arsize == 3'(byte_offset_lp) && mosi.arburst == axi4_burst_incr_gc);
      end
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (mem_els_p),
    .data_width_p (axi_data_width_p)
  ) mem (
    .clk   (clk_i),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (addr_reg),
    .wdata (mosi.wdata),
    .wmask (mosi.wstrb),
    .rdata (mem_rdata)
  );

endmodule
